// File: rtl/rgb_to_yuv_encoder_pkg.sv
// Shared definitions for the RGB-to-YUV encoder: FSM states, MAC row select,
// BT.601 coefficients (scaled by 65536) and the chroma pair average.
package rgb_to_yuv_encoder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LEAD_IN,
    COMMON,
    LEAD_OUT
  } enc_state_t;

  typedef enum logic [1:0] {
    ROW_Y,
    ROW_U,
    ROW_V
  } row_t;

  localparam logic signed [31:0] K_YR  =  32'sd16843;
  localparam logic signed [31:0] K_YG  =  32'sd33030;
  localparam logic signed [31:0] K_YB  =  32'sd6423;
  localparam logic signed [31:0] K_UR  = -32'sd9699;
  localparam logic signed [31:0] K_UG  = -32'sd19071;
  localparam logic signed [31:0] K_UB  =  32'sd28770;
  localparam logic signed [31:0] K_VR  =  32'sd28770;
  localparam logic signed [31:0] K_VG  = -32'sd24117;
  localparam logic signed [31:0] K_VB  = -32'sd4653;
  localparam logic signed [31:0] OFS_Y =  32'sd1081344;
  localparam logic signed [31:0] OFS_C =  32'sd8421376;

  function automatic logic [7:0] avg2(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b} + 9'd1;
    return 8'(s >> 1);
  endfunction

endpackage

// File: rtl/rgb_to_yuv_encoder_mac3.sv
// Three-multiplier MAC: one Y, U or V row per call, rounded offset, >>>16
// and a 0..255 clip, all combinational.
module yuv_mac3
  import rgb_to_yuv_encoder_pkg::*;
(
  input  row_t       row,
  input  logic [7:0] r,
  input  logic [7:0] g,
  input  logic [7:0] b,
  output logic [7:0] c
);

  logic signed [31:0] kr, kg, kb, ofs;
  logic signed [31:0] acc, scaled;

  always_comb begin
    kr  = K_YR;
    kg  = K_YG;
    kb  = K_YB;
    ofs = OFS_Y;
    case (row)
      ROW_U: begin
        kr  = K_UR;
        kg  = K_UG;
        kb  = K_UB;
        ofs = OFS_C;
      end
      ROW_V: begin
        kr  = K_VR;
        kg  = K_VG;
        kb  = K_VB;
        ofs = OFS_C;
      end
      default: ;
    endcase
  end

  always_comb begin
    acc = kr * $signed({24'd0, r}) + kg * $signed({24'd0, g})
        + kb * $signed({24'd0, b}) + ofs;
    scaled = acc >>> 16;
    if (scaled < 32'sd0)        c = '0;
    else if (scaled > 32'sd255) c = '1;
    else                        c = scaled[7:0];
  end

endmodule

// File: rtl/rgb_to_yuv_encoder.sv
// RGB-to-YUV encoder: reads interleaved RGB, converts with one shared MAC,
// halves chroma horizontally and writes Y/U/V segments, 12 cycles per 4 pixels.
module rgb_to_yuv_encoder
  import rgb_to_yuv_encoder_pkg::*;
#(
  parameter logic [17:0] Y_BASE     = 18'd0,
  parameter logic [17:0] U_BASE     = 18'd38400,
  parameter logic [17:0] V_BASE     = 18'd57600,
  parameter logic [17:0] RGB_BASE   = 18'd146944,
  parameter int unsigned NUM_PIXELS = 76800
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        Enable,
  output logic [17:0] SRAM_address,
  input  logic [15:0] SRAM_read_data,
  output logic [15:0] SRAM_write_data,
  output logic        SRAM_we_n,
  output logic        Done
);

  localparam logic [16:0] LAST_PIX = 17'(NUM_PIXELS - 4);

  enc_state_t  state, state_nxt;
  logic [3:0]  phase;
  logic [16:0] pix_cnt;
  logic        cmp_valid, wr_valid;
  logic [17:0] rgb_addr, y_addr, u_addr, v_addr;
  logic [15:0] cap_w [6];
  logic [15:0] cmp_w [6];
  logic [7:0]  res_y [4];
  logic [7:0]  res_u [4];
  logic [7:0]  res_v [4];
  logic [7:0]  wr_y  [4];
  logic [7:0]  wr_u  [4];
  logic [7:0]  wr_v  [4];

  logic        period_end, finish, rd_issue, wr_issue;
  logic [1:0]  pix;
  logic [3:0]  pbase, rsel;
  logic [2:0]  wbase, cap_idx;
  row_t        row;
  logic [7:0]  px_r, px_g, px_b, mac_c;

  // Each 12-cycle period overlaps three groups: reads of group n (phases 0-5),
  // MAC of group n-1 (pixel k on phases 3k..3k+2), writes of n-2 (phases 6-9).
  always_comb begin
    period_end = (phase == 4'd11);
    finish     = (state == LEAD_OUT) && !cmp_valid && (phase == 4'd10);
    rd_issue   = ((state == LEAD_IN) || (state == COMMON)) && (phase < 4'd6);
    wr_issue   = (state != IDLE) && wr_valid && (phase >= 4'd6) && (phase <= 4'd9);
    cap_idx    = 3'(phase - 4'd3);
  end

  always_comb begin
    if (phase < 4'd3)      pix = 2'd0;
    else if (phase < 4'd6) pix = 2'd1;
    else if (phase < 4'd9) pix = 2'd2;
    else                   pix = 2'd3;
    pbase = {1'b0, pix, 1'b0} + {2'b00, pix};
    rsel  = phase - pbase;
    case (rsel)
      4'd0:    row = ROW_Y;
      4'd1:    row = ROW_U;
      default: row = ROW_V;
    endcase
    wbase = pix[1] ? 3'd3 : 3'd0;
    if (!pix[0]) begin
      px_r = cmp_w[wbase][15:8];
      px_g = cmp_w[wbase][7:0];
      px_b = cmp_w[wbase + 3'd1][15:8];
    end else begin
      px_r = cmp_w[wbase + 3'd1][7:0];
      px_g = cmp_w[wbase + 3'd2][15:8];
      px_b = cmp_w[wbase + 3'd2][7:0];
    end
  end

  yuv_mac3 u_mac (
    .row (row),
    .r   (px_r),
    .g   (px_g),
    .b   (px_b),
    .c   (mac_c)
  );

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Enable) state_nxt = LEAD_IN;
      LEAD_IN,
      COMMON:  if (period_end) state_nxt = (pix_cnt == LAST_PIX) ? LEAD_OUT : COMMON;
      LEAD_OUT: if (finish) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      phase           <= '0;
      pix_cnt         <= '0;
      cmp_valid       <= 1'b0;
      wr_valid        <= 1'b0;
      rgb_addr        <= '0;
      y_addr          <= '0;
      u_addr          <= '0;
      v_addr          <= '0;
      cap_w           <= '{default: '0};
      cmp_w           <= '{default: '0};
      res_y           <= '{default: '0};
      res_u           <= '{default: '0};
      res_v           <= '{default: '0};
      wr_y            <= '{default: '0};
      wr_u            <= '{default: '0};
      wr_v            <= '{default: '0};
      SRAM_address    <= '0;
      SRAM_write_data <= '0;
      SRAM_we_n       <= 1'b1;
      Done            <= 1'b0;
    end else begin
      Done      <= finish;
      SRAM_we_n <= 1'b1;
      if (state == IDLE) begin
        phase <= '0;
        if (Enable) begin
          rgb_addr  <= RGB_BASE;
          y_addr    <= Y_BASE;
          u_addr    <= U_BASE;
          v_addr    <= V_BASE;
          pix_cnt   <= '0;
          cmp_valid <= 1'b0;
          wr_valid  <= 1'b0;
        end
      end else begin
        phase <= (period_end || finish) ? 4'd0 : phase + 4'd1;
        if (period_end) begin
          cmp_valid <= (state != LEAD_OUT);
          wr_valid  <= cmp_valid;
          cmp_w     <= cap_w;
          if (state != LEAD_OUT) pix_cnt <= pix_cnt + 17'd4;
        end
        if ((phase >= 4'd3) && (phase <= 4'd8)) cap_w[cap_idx] <= SRAM_read_data;
        case (row)
          ROW_Y:   res_y[pix] <= mac_c;
          ROW_U:   res_u[pix] <= mac_c;
          default: res_v[pix] <= mac_c;
        endcase
        // Phase 0 overwrites only res_y[0]; the copy still sees the old value.
        if (phase == 4'd0) begin
          wr_y <= res_y;
          wr_u <= res_u;
          wr_v <= res_v;
        end
        if (rd_issue) begin
          SRAM_address <= rgb_addr;
          rgb_addr     <= rgb_addr + 18'd1;
        end
        if (wr_issue) begin
          SRAM_we_n <= 1'b0;
          case (phase)
            4'd6: begin
              SRAM_address    <= y_addr;
              SRAM_write_data <= {wr_y[0], wr_y[1]};
              y_addr          <= y_addr + 18'd1;
            end
            4'd7: begin
              SRAM_address    <= y_addr;
              SRAM_write_data <= {wr_y[2], wr_y[3]};
              y_addr          <= y_addr + 18'd1;
            end
            4'd8: begin
              SRAM_address    <= u_addr;
              SRAM_write_data <= {avg2(wr_u[0], wr_u[1]), avg2(wr_u[2], wr_u[3])};
              u_addr          <= u_addr + 18'd1;
            end
            default: begin
              SRAM_address    <= v_addr;
              SRAM_write_data <= {avg2(wr_v[0], wr_v[1]), avg2(wr_v[2], wr_v[3])};
              v_addr          <= v_addr + 18'd1;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_rgb_to_yuv_encoder.sv
// Bench for rgb_to_yuv_encoder: SRAM model, BT.601 reference model producing
// the expected write stream, and literal checks on known colours.
module tb_rgb_to_yuv_encoder;

  localparam int          NP    = 64;
  localparam int          G     = NP / 4;
  localparam int          IMG_W = NP * 3 / 2;
  localparam logic [17:0] YB    = 18'd0;
  localparam logic [17:0] UB    = 18'd38400;
  localparam logic [17:0] VB    = 18'd57600;
  localparam logic [17:0] RB    = 18'd146944;
  localparam int          TMO   = (G + 4) * 12 + 40;

  typedef struct packed {
    logic [17:0] a;
    logic [15:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [17:0] addr;
  logic [15:0] rdata, wdata;
  logic        we_n, done;

  logic [15:0] img  [IMG_W];
  logic [15:0] outm [0:262143];
  logic [15:0] rd_d1, rd_d2;

  wr_t         exp_q [$];
  int          n_vec = 0;
  int          n_err = 0;
  int unsigned cyc = 0;
  int unsigned wr_idx = 0;
  int unsigned grp_cyc = 0;
  int unsigned last_wr_cyc = 0;
  logic        prev_done = 1'b0;

  rgb_to_yuv_encoder #(
    .Y_BASE     (YB),
    .U_BASE     (UB),
    .V_BASE     (VB),
    .RGB_BASE   (RB),
    .NUM_PIXELS (NP)
  ) dut (
    .Clock           (clk),
    .Resetn          (rst_n),
    .Enable          (enable),
    .SRAM_address    (addr),
    .SRAM_read_data  (rdata),
    .SRAM_write_data (wdata),
    .SRAM_we_n       (we_n),
    .Done            (done)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] rd_word(input logic [17:0] a);
    int idx;
    idx = int'(a) - int'(RB);
    if (a >= RB && idx < IMG_W) return img[idx];
    return outm[a];
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!we_n) outm[addr] <= wdata;
    rd_d1 <= rd_word(addr);
    rd_d2 <= rd_d1;
  end
  assign rdata = rd_d2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference conversion: plain integer arithmetic from the BT.601 formulas.
  function automatic int conv(input int kr, input int kg, input int kb, input int ofs,
                              input int r, input int g, input int b);
    int s;
    s = (kr * r + kg * g + kb * b + ofs) >>> 16;
    if (s < 0) s = 0;
    if (s > 255) s = 255;
    return s;
  endfunction

  function automatic logic [7:0] avg(input int a, input int b);
    return 8'((a + b + 1) / 2);
  endfunction

  task automatic build_expected();
    int y[4], u[4], v[4];
    int w, r, g, b;
    logic [15:0] w0, w1, w2;
    for (int grp = 0; grp < G; grp++) begin
      for (int k = 0; k < 4; k++) begin
        w  = 3 * ((4 * grp + k) / 2);
        w0 = img[w];
        w1 = img[w + 1];
        w2 = img[w + 2];
        if (k % 2 == 0) begin
          r = int'(w0[15:8]); g = int'(w0[7:0]); b = int'(w1[15:8]);
        end else begin
          r = int'(w1[7:0]); g = int'(w2[15:8]); b = int'(w2[7:0]);
        end
        y[k] = conv(16843, 33030, 6423, 1081344, r, g, b);
        u[k] = conv(-9699, -19071, 28770, 8421376, r, g, b);
        v[k] = conv(28770, -24117, -4653, 8421376, r, g, b);
      end
      exp_q.push_back({18'(YB + 18'(2 * grp)),     8'(y[0]), 8'(y[1])});
      exp_q.push_back({18'(YB + 18'(2 * grp + 1)), 8'(y[2]), 8'(y[3])});
      exp_q.push_back({18'(UB + 18'(grp)), avg(u[0], u[1]), avg(u[2], u[3])});
      exp_q.push_back({18'(VB + 18'(grp)), avg(v[0], v[1]), avg(v[2], v[3])});
    end
  endtask

  // Single compare process: every write against the model stream, plus timing.
  always @(negedge clk) begin
    wr_t e;
    if (!rst_n) begin
      wr_idx    = 0;
      prev_done = 1'b0;
    end else begin
      if (!we_n) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write_addr", 32'(addr), 32'h3FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("write_addr", 32'(addr), 32'(e.a));
          chk("write_data", 32'(wdata), 32'(e.d));
          if (wr_idx % 4 == 0) begin
            if (wr_idx / 4 >= 1 && wr_idx / 4 <= G - 2)
              chk("group_spacing", cyc - grp_cyc, 32'd12);
            grp_cyc = cyc;
          end
          wr_idx++;
          last_wr_cyc = cyc;
        end
      end
      if (done) begin
        chk("done_single_pulse", 32'(prev_done), 32'd0);
        chk("writes_per_pass", wr_idx, 32'(4 * G));
        chk("we_n_at_done", 32'(we_n), 32'd1);
        chk("done_near_last_write", 32'((cyc - last_wr_cyc) <= 2), 32'd1);
        wr_idx = 0;
      end
      prev_done = done;
    end
  end

  task automatic wait_done(input string name);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!done && k < TMO);
    chk(name, 32'(done), 32'd1);
  endtask

  task automatic start_pass();
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
  endtask

  task automatic fill(input logic [15:0] val);
    for (int i = 0; i < IMG_W; i++) img[i] = val;
  endtask

  task automatic fill_random();
    for (int i = 0; i < IMG_W; i++) img[i] = 16'($urandom);
  endtask

  task automatic check_uniform(input string name, input logic [15:0] yw, input logic [15:0] cw);
    for (int grp = 0; grp < G; grp++) begin
      chk({name, "_y0"}, 32'(outm[YB + 18'(2 * grp)]), 32'(yw));
      chk({name, "_y1"}, 32'(outm[YB + 18'(2 * grp + 1)]), 32'(yw));
      chk({name, "_u"}, 32'(outm[UB + 18'(grp)]), 32'(cw));
      chk({name, "_v"}, 32'(outm[VB + 18'(grp)]), 32'(cw));
    end
  endtask

  initial begin
    int k;
    rst_n  = 1'b0;
    enable = 1'b0;
    fill(16'h0000);
    repeat (3) @(negedge clk);
    chk("reset_addr", 32'(addr), 32'd0);
    chk("reset_wdata", 32'(wdata), 32'd0);
    chk("reset_we_n", 32'(we_n), 32'd1);
    chk("reset_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    fill(16'h0000);
    build_expected();
    start_pass();
    wait_done("black_done");
    check_uniform("black", 16'h1010, 16'h8080);
    chk("black_last_v_addr", 32'(dut.v_addr), 32'(VB + 18'(G)));

    fill(16'hFFFF);
    build_expected();
    start_pass();
    wait_done("white_done");
    check_uniform("white", 16'hEBEB, 16'h8080);

    fill_random();
    img[0] = 16'h0000; img[1] = 16'h00FF; img[2] = 16'h0000;
    img[3] = 16'h0000; img[4] = 16'h0000; img[5] = 16'h0000;
    build_expected();
    start_pass();
    wait_done("red_done");
    chk("red_y0", 32'(outm[YB]), 32'h1052);
    chk("red_u0", 32'(outm[UB]), 32'h6D80);
    chk("red_v0", 32'(outm[VB]), 32'hB880);

    fill_random();
    img[0] = 16'h0000; img[1] = 16'hFF00; img[2] = 16'h00FF;
    img[3] = 16'h0000; img[4] = 16'hFF00; img[5] = 16'h00FF;
    build_expected();
    start_pass();
    wait_done("blue_done");
    chk("blue_y0", 32'(outm[YB]), 32'h2929);
    chk("blue_y1", 32'(outm[YB + 18'd1]), 32'h2929);
    chk("blue_u0", 32'(outm[UB]), 32'hF0F0);
    chk("blue_v0", 32'(outm[VB]), 32'h6E6E);

    // Random image with a stray Enable pulse mid-pass.
    fill_random();
    build_expected();
    start_pass();
    repeat (40) @(negedge clk);
    start_pass();
    wait_done("rand_done");

    // Enable held high across Done: two back-to-back passes.
    fill_random();
    build_expected();
    build_expected();
    enable = 1'b1;
    wait_done("hold_done1");
    wait_done("hold_done2");
    enable = 1'b0;
    repeat (20) @(negedge clk);
    chk("hold_queue_drained", 32'(exp_q.size()), 32'd0);

    // Abort in the middle of group 5, then a clean rerun.
    fill_random();
    build_expected();
    start_pass();
    k = 0;
    while (wr_idx < 20 && k < TMO) begin
      @(negedge clk);
      k++;
    end
    chk("abort_reached", 32'(wr_idx >= 20), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_we_n", 32'(we_n), 32'd1);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_addr", 32'(addr), 32'd0);
    repeat (2) @(negedge clk);
    exp_q.delete();
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    build_expected();
    start_pass();
    k = 0;
    while (addr == 18'd0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("restart_first_read", 32'(addr), 32'(RB));
    wait_done("rerun_done");
    repeat (5) @(negedge clk);
    chk("rerun_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
